// File: rtl/ddr3_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr3_rd_arbiter_if
//   One requester port of the DDR3 read arbiter.
//   master : requester side (drives read/addr/burst, receives accept/rdata/rvalid)
//   slave  : arbiter side
//   read   : read request, held until accept
//   addr   : burst start word address, stable while read=1
//   burst  : beats in burst (1..2^BURST_W-1)
//   accept : 1-cycle pulse when the EMIF takes the command
//   rdata  : returned read beat
//   rvalid : rdata valid
// ---------------------------------------------------------------------------
interface ddr3_rd_arbiter_if #(
   parameter int unsigned ADDR_W  = 22,
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned BURST_W = 5
);
   logic               read;
   logic [ADDR_W-1:0]  addr;
   logic [BURST_W-1:0] burst;
   logic               accept;
   logic [DATA_W-1:0]  rdata;
   logic               rvalid;

   modport master (output read, addr, burst, input accept, rdata, rvalid);
   modport slave  (input read, addr, burst, output accept, rdata, rvalid);
endinterface

// File: rtl/ddr3_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_rd_arbiter
//   Two-port read arbiter/sequencer in front of the DDR3 EMIF Avalon-MM read
//   port. Port 0 is the frame/pixel reader, port 1 the pattern/config loader.
//   One burst command is granted at a time and held until the EMIF accepts it;
//   each accepted burst is logged in a tag FIFO ({port, burst}) so returning
//   beats are steered back to the issuing port.
//
//   Ports:
//     mem_clk, mem_rst        EMIF user clock, async active-high reset
//     req0, req1              requester ports (ddr3_rd_arbiter_if.slave)
//     ddr3_emif_*             Avalon-MM read command / read data to the EMIF
//     busy                    command pending or bursts outstanding
//     err                     sticky: burst==0 request, or read beat with no tag
//
//   Configuration macro:
//     DDR3_RD_ARB_RR_EN       defined   : round-robin arbitration
//                             undefined : fixed priority, port 0 wins
// ---------------------------------------------------------------------------
module ddr3_rd_arbiter #(
   parameter int unsigned ADDR_W    = 22,
   parameter int unsigned DATA_W    = 256,
   parameter int unsigned BURST_W   = 5,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic                mem_clk,
   input  logic                mem_rst,
   ddr3_rd_arbiter_if.slave    req0,
   ddr3_rd_arbiter_if.slave    req1,
   input  logic                ddr3_emif_ready,
   output logic                ddr3_emif_read,
   output logic [ADDR_W-1:0]   ddr3_emif_addr,
   output logic [BURST_W-1:0]  ddr3_emif_burst_count,
   input  logic [DATA_W-1:0]   ddr3_emif_read_data,
   input  logic                ddr3_emif_rddata_valid,
   output logic                busy,
   output logic                err
);
   localparam int unsigned        PTR_W    = $clog2(TAG_DEPTH);
   localparam logic [PTR_W:0]     OCC_FULL = (PTR_W+1)'(TAG_DEPTH);
   localparam logic [PTR_W:0]     OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [BURST_W-1:0] BEAT_ONE = BURST_W'(1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t             state;
   logic               grant_port;
   logic [BURST_W:0]   tag_mem [TAG_DEPTH];   // {port, burst}
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     occ;
   logic [BURST_W-1:0] beat_cnt;
   logic               rvalid0_q, rvalid1_q;
   logic [DATA_W-1:0]  rdata0_q, rdata1_q;

   logic               v0, v1, pick1;
   logic               fifo_full, fifo_empty;
   logic               push, pop, beat_ok;
   logic               head_port;
   logic [BURST_W-1:0] head_burst;

   // A zero-length burst is never eligible; it only raises err.
   assign v0 = req0.read && (req0.burst != '0);
   assign v1 = req1.read && (req1.burst != '0);

   assign fifo_full  = (occ == OCC_FULL);
   assign fifo_empty = (occ == '0);
   assign push       = (state == ISSUE) && ddr3_emif_ready;
   assign beat_ok    = ddr3_emif_rddata_valid && !fifo_empty;
   assign {head_port, head_burst} = tag_mem[rd_ptr];
   assign pop        = beat_ok && (beat_cnt == head_burst - BEAT_ONE);

   // Accept must be visible in the handshake cycle itself, otherwise the
   // requester's still-high read would be re-granted on return to IDLE.
   assign req0.accept = push && !grant_port;
   assign req1.accept = push &&  grant_port;
   assign req0.rvalid = rvalid0_q;
   assign req1.rvalid = rvalid1_q;
   assign req0.rdata  = rdata0_q;
   assign req1.rdata  = rdata1_q;
   assign busy        = (state == ISSUE) || !fifo_empty;

`ifdef DDR3_RD_ARB_RR_EN
   // Port granted by the most recent accept; the other port wins a tie.
   logic last_grant;

   always_ff @(posedge mem_clk or posedge mem_rst) begin
      if (mem_rst)   last_grant <= 1'b0;
      else if (push) last_grant <= grant_port;
   end

   assign pick1 = v1 && (!v0 || !last_grant);
`else
   assign pick1 = v1 && !v0;
`endif

   // Command FSM
   always_ff @(posedge mem_clk or posedge mem_rst) begin
      if (mem_rst) begin
         state                 <= IDLE;
         ddr3_emif_read        <= 1'b0;
         ddr3_emif_addr        <= '0;
         ddr3_emif_burst_count <= '0;
         grant_port            <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((v0 || v1) && !fifo_full) begin
                  state                 <= ISSUE;
                  ddr3_emif_read        <= 1'b1;
                  grant_port            <= pick1;
                  ddr3_emif_addr        <= pick1 ? req1.addr  : req0.addr;
                  ddr3_emif_burst_count <= pick1 ? req1.burst : req0.burst;
               end
            end
            ISSUE: begin
               if (ddr3_emif_ready) begin
                  state          <= IDLE;
                  ddr3_emif_read <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag storage needs no reset; validity is tracked by occ.
   always_ff @(posedge mem_clk) begin
      if (push) tag_mem[wr_ptr] <= {grant_port, ddr3_emif_burst_count};
   end

   // Tag FIFO pointers / occupancy and beat counter
   always_ff @(posedge mem_clk or posedge mem_rst) begin
      if (mem_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         beat_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
         if (beat_ok) beat_cnt <= pop ? '0 : beat_cnt + BEAT_ONE;
      end
   end

   // Return path: registered steering to the head tag's port
   always_ff @(posedge mem_clk or posedge mem_rst) begin
      if (mem_rst) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= beat_ok && !head_port;
         rvalid1_q <= beat_ok &&  head_port;
         if (beat_ok && !head_port) rdata0_q <= ddr3_emif_read_data;
         if (beat_ok &&  head_port) rdata1_q <= ddr3_emif_read_data;
      end
   end

   // Sticky error
   always_ff @(posedge mem_clk or posedge mem_rst) begin
      if (mem_rst) begin
         err <= 1'b0;
      end else if ((req0.read && (req0.burst == '0)) ||
                   (req1.read && (req1.burst == '0)) ||
                   (ddr3_emif_rddata_valid && fifo_empty)) begin
         err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_rd_arbiter
//   Directed self-checking bench for ddr3_rd_arbiter (DATA_W reduced to 32).
//   Expected values are hand-computed per scenario; the arbitration order
//   follows DDR3_RD_ARB_RR_EN when defined.
// ---------------------------------------------------------------------------
module tb_ddr3_rd_arbiter;
   localparam int unsigned AW = 22;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 5;
   localparam int unsigned TD = 8;

   logic          mem_clk = 1'b0;
   logic          mem_rst = 1'b1;
   logic          ddr3_emif_ready = 1'b0;
   logic          ddr3_emif_read;
   logic [AW-1:0] ddr3_emif_addr;
   logic [BW-1:0] ddr3_emif_burst_count;
   logic [DW-1:0] ddr3_emif_read_data = '0;
   logic          ddr3_emif_rddata_valid = 1'b0;
   logic          busy;
   logic          err;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] last_d0 = '0;
   logic [DW-1:0] last_d1 = '0;
   int            n_grant;
   bit            got_port [4];
   bit            exp_port [4];

   ddr3_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) r0 ();
   ddr3_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) r1 ();

   ddr3_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TAG_DEPTH(TD)) dut (
      .mem_clk                (mem_clk),
      .mem_rst                (mem_rst),
      .req0                   (r0),
      .req1                   (r1),
      .ddr3_emif_ready        (ddr3_emif_ready),
      .ddr3_emif_read         (ddr3_emif_read),
      .ddr3_emif_addr         (ddr3_emif_addr),
      .ddr3_emif_burst_count  (ddr3_emif_burst_count),
      .ddr3_emif_read_data    (ddr3_emif_read_data),
      .ddr3_emif_rddata_valid (ddr3_emif_rddata_valid),
      .busy                   (busy),
      .err                    (err)
   );

   always #5 mem_clk = ~mem_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic do_reset();
      mem_rst = 1'b1;
      tick();
      tick();
      mem_rst = 1'b0;
      last_d0 = '0;
      last_d1 = '0;
   endtask

   task automatic wait_accept(input string tag, input bit port);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         got = port ? r1.accept : r0.accept;
      end
      check(tag, got, 1'b1);
   endtask

   task automatic send_beats(input int n, input bit port, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         ddr3_emif_rddata_valid = 1'b1;
         ddr3_emif_read_data    = base + DW'(i);
         tick();
         check("rvalid_own",   port ? r1.rvalid : r0.rvalid, 1'b1);
         check("rvalid_other", port ? r0.rvalid : r1.rvalid, 1'b0);
         check("rdata_own",    port ? r1.rdata  : r0.rdata,  base + DW'(i));
         check("rdata_hold",   port ? r0.rdata  : r1.rdata,  port ? last_d0 : last_d1);
         if (port) last_d1 = base + DW'(i);
         else      last_d0 = base + DW'(i);
      end
      ddr3_emif_rddata_valid = 1'b0;
   endtask

   initial begin
      r0.read = 1'b0; r0.addr = '0; r0.burst = '0;
      r1.read = 1'b0; r1.addr = '0; r1.burst = '0;

      // Reset state
      do_reset();
      check("rst_read",    ddr3_emif_read, 1'b0);
      check("rst_addr",    ddr3_emif_addr, '0);
      check("rst_bc",      ddr3_emif_burst_count, '0);
      check("rst_acc0",    r0.accept, 1'b0);
      check("rst_rvalid0", r0.rvalid, 1'b0);
      check("rst_rvalid1", r1.rvalid, 1'b0);
      check("rst_busy",    busy, 1'b0);
      check("rst_err",     err, 1'b0);

      // 1: single burst, ready=1, 1-cycle issue and return latency
      ddr3_emif_ready = 1'b1;
      r0.read = 1'b1; r0.addr = 22'h8; r0.burst = 5'd4;
      tick();
      check("t1_read", ddr3_emif_read, 1'b1);
      check("t1_addr", ddr3_emif_addr, 22'h8);
      check("t1_bc",   ddr3_emif_burst_count, 5'd4);
      check("t1_acc0", r0.accept, 1'b1);
      r0.read = 1'b0;
      tick();
      check("t1_read_off", ddr3_emif_read, 1'b0);
      check("t1_acc_off",  r0.accept, 1'b0);
      check("t1_busy",     busy, 1'b1);
      send_beats(3, 1'b0, 32'h1000);
      check("t1_busy_mid", busy, 1'b1);
      send_beats(1, 1'b0, 32'h1003);
      check("t1_busy_end", busy, 1'b0);
      tick();
      check("t1_rvalid_end", r0.rvalid, 1'b0);
      check("t1_err", err, 1'b0);

      // 2: EMIF stalls for 5 cycles
      ddr3_emif_ready = 1'b0;
      r0.read = 1'b1; r0.addr = 22'h123; r0.burst = 5'd2;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t2_read", ddr3_emif_read, 1'b1);
         check("t2_addr", ddr3_emif_addr, 22'h123);
         check("t2_bc",   ddr3_emif_burst_count, 5'd2);
         check("t2_acc",  r0.accept, 1'b0);
         if (i < 4) tick();
      end
      ddr3_emif_ready = 1'b1;
      #1;
      check("t2_acc_rdy", r0.accept, 1'b1);
      r0.read = 1'b0;
      tick();
      check("t2_read_off", ddr3_emif_read, 1'b0);
      check("t2_acc_once", r0.accept, 1'b0);
      send_beats(2, 1'b0, 32'h2000);
      check("t2_busy_end", busy, 1'b0);

      // 3: both ports held; the last accept so far was port 0
`ifdef DDR3_RD_ARB_RR_EN
      exp_port = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      r0.read = 1'b1; r0.addr = 22'h10; r0.burst = 5'd2;
      r1.read = 1'b1; r1.addr = 22'h20; r1.burst = 5'd2;
      n_grant = 0;
      for (int c = 0; c < 20 && n_grant < 4; c++) begin
         tick();
         if (r0.accept) begin got_port[n_grant] = 1'b0; n_grant++; end
         else if (r1.accept) begin got_port[n_grant] = 1'b1; n_grant++; end
      end
      r0.read = 1'b0; r1.read = 1'b0;
      check("t3_ngrant", n_grant, 4);
      for (int i = 0; i < 4; i++) check("t3_order", got_port[i], exp_port[i]);
      tick();
      for (int i = 0; i < 4; i++) send_beats(2, exp_port[i], 32'h3000 + 32'(i * 16));
      check("t3_busy_end", busy, 1'b0);

      // 4: tag FIFO full blocks the 9th grant until one pop
      r0.read = 1'b1; r0.burst = 5'd1;
      for (int k = 0; k < 8; k++) begin
         r0.addr = AW'(k);
         wait_accept("t4_acc", 1'b0);
      end
      r0.addr = 22'h8;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_full_read", ddr3_emif_read, 1'b0);
         check("t4_full_acc",  r0.accept, 1'b0);
      end
      check("t4_full_busy", busy, 1'b1);
      send_beats(1, 1'b0, 32'h4000);
      check("t4_pop_read", ddr3_emif_read, 1'b0);
      tick();
      check("t4_9th_read", ddr3_emif_read, 1'b1);
      check("t4_9th_addr", ddr3_emif_addr, 22'h8);
      check("t4_9th_acc",  r0.accept, 1'b1);
      r0.read = 1'b0;
      tick();
      send_beats(8, 1'b0, 32'h4100);
      check("t4_busy_end", busy, 1'b0);

      // 5: returns steered by tag order
      r1.read = 1'b1; r1.addr = 22'h200; r1.burst = 5'd3;
      wait_accept("t5_acc1", 1'b1);
      r1.read = 1'b0;
      r0.read = 1'b1; r0.addr = 22'h300; r0.burst = 5'd1;
      wait_accept("t5_acc0", 1'b0);
      r0.read = 1'b0;
      tick();
      send_beats(3, 1'b1, 32'h5000);
      send_beats(1, 1'b0, 32'h5100);
      check("t5_busy_end", busy, 1'b0);
      check("t5_err", err, 1'b0);

      // 6a: zero-length burst request
      do_reset();
      r1.read = 1'b1; r1.addr = 22'h55; r1.burst = 5'd0;
      tick();
      check("t6_bz_err",  err, 1'b1);
      check("t6_bz_read", ddr3_emif_read, 1'b0);
      tick();
      tick();
      check("t6_bz_read2", ddr3_emif_read, 1'b0);
      check("t6_bz_acc",   r1.accept, 1'b0);
      r1.read = 1'b0;
      tick();
      check("t6_bz_sticky", err, 1'b1);

      // 6b: read beat with no outstanding tag
      do_reset();
      check("t6_err_clr", err, 1'b0);
      ddr3_emif_rddata_valid = 1'b1; ddr3_emif_read_data = 32'hDEAD;
      tick();
      ddr3_emif_rddata_valid = 1'b0;
      check("t6_em_err", err, 1'b1);
      check("t6_em_rv0", r0.rvalid, 1'b0);
      check("t6_em_rv1", r1.rvalid, 1'b0);
      check("t6_em_busy", busy, 1'b0);

      // 6c: reset mid-burst, then stale beats
      do_reset();
      r0.read = 1'b1; r0.addr = 22'h40; r0.burst = 5'd4;
      wait_accept("t6_acc", 1'b0);
      r0.read = 1'b0;
      tick();
      send_beats(2, 1'b0, 32'h6000);
      mem_rst = 1'b1;
      tick();
      check("t6_rst_read",   ddr3_emif_read, 1'b0);
      check("t6_rst_rv0",    r0.rvalid, 1'b0);
      check("t6_rst_rdata0", r0.rdata, '0);
      check("t6_rst_busy",   busy, 1'b0);
      check("t6_rst_err",    err, 1'b0);
      mem_rst = 1'b0;
      last_d0 = '0;
      ddr3_emif_rddata_valid = 1'b1; ddr3_emif_read_data = 32'h6002;
      tick();
      ddr3_emif_rddata_valid = 1'b0;
      check("t6_stale_rv0", r0.rvalid, 1'b0);
      check("t6_stale_err", err, 1'b1);
      tick();
      check("t6_stale_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
